// File: rtl/irrigation_valve_ctrl_if.sv
// Irrigation valve controller bundle: run request and
// fuzzy-stage inputs plus valve/status outputs.
interface irrigation_valve_ctrl_if;
  logic        start;
  logic [7:0]  irrigation_time;
  logic        rain_present;
  logic        manual_stop;
  logic        valve_on;
  logic        busy;
  logic [7:0]  remaining_s;
  logic        done;
  logic [15:0] run_count;

  modport master (
    output start, irrigation_time,
    output rain_present, manual_stop,
    input  valve_on, busy, remaining_s,
    input  done, run_count
  );

  modport slave (
    input  start, irrigation_time,
    input  rain_present, manual_stop,
    output valve_on, busy, remaining_s,
    output done, run_count
  );
endinterface

// File: rtl/irrigation_valve_ctrl.sv
// Timed irrigation valve sequencer: IDLE -> WATER -> COOLDOWN.
// Define RAIN_ABORT_EN to let mid-run rain abort a WATER phase.
module irrigation_valve_ctrl #(
  parameter int          TICKS_PER_SEC = 50000000,
  parameter logic [7:0]  COOLDOWN_S    = 8'd60
) (
  input logic clk,
  input logic reset_n,
  irrigation_valve_ctrl_if.slave io
);

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE, WATER, COOLDOWN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          valve_q, valve_d;
  logic          done_q, done_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ev_skip, ev_end, ev_abort;
  logic          abort;

`ifdef RAIN_ABORT_EN
  assign abort = io.manual_stop | io.rain_present;
`else
  assign abort = io.manual_stop;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      presc_q <= '0;
      valve_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      valve_q <= valve_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start in the cycle done is high is dropped so a
  // back-to-back skip can never stretch done to two cycles.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    presc_d  = presc_q;
    ev_skip  = 1'b0;
    ev_end   = 1'b0;
    ev_abort = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start && !io.manual_stop && !done_q) begin
          if (io.irrigation_time == 8'd0 || io.rain_present) begin
            ev_skip = 1'b1;
          end else begin
            state_d = WATER;
            rem_d   = io.irrigation_time;
            presc_d = '0;
          end
        end
      end
      WATER: begin
        if (abort) begin
          ev_abort = 1'b1;
        end else if (presc_q == PMAX) begin
          presc_d = '0;
          if (rem_q == 8'd1) ev_end = 1'b1;
          else rem_d = rem_q - 8'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (ev_abort || ev_end) begin
          presc_d = '0;
          if (COOLDOWN_S == 8'd0) begin
            state_d = IDLE;
            rem_d   = 8'd0;
          end else begin
            state_d = COOLDOWN;
            rem_d   = COOLDOWN_S;
          end
        end
      end
      COOLDOWN: begin
        if (presc_q == PMAX) begin
          presc_d = '0;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 8'd0;
        presc_d = '0;
      end
    endcase
  end

  always_comb begin
    valve_d = (state_d == WATER);
    done_d  = ev_skip | ev_end | ev_abort;
    cnt_d   = cnt_q + 16'(ev_end);
  end

  assign io.valve_on    = valve_q;
  assign io.busy        = (state_q != IDLE);
  assign io.remaining_s = rem_q;
  assign io.done        = done_q;
  assign io.run_count   = cnt_q;

endmodule

// File: tb/tb_irrigation_valve_ctrl.sv
// Directed bench for irrigation_valve_ctrl at
// TICKS_PER_SEC=4, COOLDOWN_S=2.
module tb_irrigation_valve_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  irrigation_valve_ctrl_if io ();

  irrigation_valve_ctrl #(
    .TICKS_PER_SEC(4),
    .COOLDOWN_S(8'd2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(io)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [7:0] t, input logic rain);
    io.start           = 1'b1;
    io.irrigation_time = t;
    io.rain_present    = rain;
    @(posedge clk);
    #1;
    io.start        = 1'b0;
    io.rain_present = 1'b0;
  endtask

  task automatic run_measure(input int stop_at,
                             input int rain_at,
                             input bit inj,
                             output int von,
                             output int bafter,
                             output int dones,
                             output int first_rem);
    bit pd  = 1'b0;
    bit to  = 1'b1;
    int dbl = 0;
    von = 0; bafter = 0; dones = 0; first_rem = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      io.start           = inj && io.busy && (i == 3 || i == 14);
      io.manual_stop     = (i == stop_at);
      io.rain_present    = (i == rain_at);
      io.irrigation_time = 8'd9;
      if (i == 0) first_rem = int'(io.remaining_s);
      if (io.valve_on) von++;
      else if (io.busy) bafter++;
      if (io.done) dones++;
      if (io.done && pd) dbl++;
      pd = io.done;
      if (!io.busy) begin
        to = 1'b0;
        break;
      end
    end
    io.start        = 1'b0;
    io.manual_stop  = 1'b0;
    io.rain_present = 1'b0;
    check("run_timeout", 32'(to), 0);
    check("done_double", dbl, 0);
  endtask

  int von, baf, dn, fr;

  initial begin
    reset_n            = 1'b0;
    io.start           = 1'b0;
    io.irrigation_time = 8'd0;
    io.rain_present    = 1'b0;
    io.manual_stop     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valve", 32'(io.valve_on), 0);
    check("rst_busy", 32'(io.busy), 0);
    check("rst_rem", 32'(io.remaining_s), 0);
    check("rst_done", 32'(io.done), 0);
    check("rst_cnt", 32'(io.run_count), 0);

    // full run started in the first cycle out of reset
    reset_n = 1'b1;
    kick(8'd3, 1'b0);
    run_measure(-1, -1, 1'b0, von, baf, dn, fr);
    check("t3_first_rem", fr, 3);
    check("t3_valve", von, 12);
    check("t3_cool", baf, 8);
    check("t3_done", dn, 1);
    check("t3_cnt", 32'(io.run_count), 1);

    // starts injected during WATER and COOLDOWN
    kick(8'd3, 1'b0);
    run_measure(-1, -1, 1'b1, von, baf, dn, fr);
    check("ign_valve", von, 12);
    check("ign_cool", baf, 8);
    check("ign_cnt", 32'(io.run_count), 2);
    check("ign_idle", 32'(io.busy), 0);

    // skipped requests
    kick(8'd0, 1'b0);
    @(negedge clk);
    check("skip0_done", 32'(io.done), 1);
    check("skip0_valve", 32'(io.valve_on), 0);
    check("skip0_busy", 32'(io.busy), 0);
    @(negedge clk);
    check("skip0_done_off", 32'(io.done), 0);
    kick(8'd5, 1'b1);
    @(negedge clk);
    check("skipr_done", 32'(io.done), 1);
    check("skipr_busy", 32'(io.busy), 0);
    @(negedge clk);
    check("skipr_done_off", 32'(io.done), 0);
    check("skip_cnt", 32'(io.run_count), 2);

    // start held over two cycles of zero time
    io.start           = 1'b1;
    io.irrigation_time = 8'd0;
    @(posedge clk);
    @(negedge clk);
    check("hold_done1", 32'(io.done), 1);
    @(posedge clk);
    @(negedge clk);
    check("hold_done2", 32'(io.done), 0);
    io.start = 1'b0;

    // manual_stop in IDLE beats start
    io.manual_stop = 1'b1;
    kick(8'd3, 1'b0);
    io.manual_stop = 1'b0;
    @(negedge clk);
    check("idlestop_busy", 32'(io.busy), 0);
    check("idlestop_done", 32'(io.done), 0);

    // manual abort at WATER cycle 5
    kick(8'd4, 1'b0);
    run_measure(4, -1, 1'b0, von, baf, dn, fr);
    check("abort_valve", von, 5);
    check("abort_cool", baf, 8);
    check("abort_done", dn, 1);
    check("abort_cnt", 32'(io.run_count), 2);

    // rain during WATER
    kick(8'd4, 1'b0);
    run_measure(-1, 4, 1'b0, von, baf, dn, fr);
`ifdef RAIN_ABORT_EN
    check("rain_valve", von, 5);
    check("rain_cnt", 32'(io.run_count), 2);
`else
    check("rain_valve", von, 16);
    check("rain_cnt", 32'(io.run_count), 3);
`endif
    check("rain_cool", baf, 8);
    check("rain_done", dn, 1);

    // reset mid-WATER, then immediate restart
    kick(8'd3, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.remaining_s == 8'd2) break;
    end
    check("mid_rem", 32'(io.remaining_s), 2);
    check("mid_valve", 32'(io.valve_on), 1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_valve", 32'(io.valve_on), 0);
    check("mrst_busy", 32'(io.busy), 0);
    check("mrst_rem", 32'(io.remaining_s), 0);
    check("mrst_done", 32'(io.done), 0);
    check("mrst_cnt", 32'(io.run_count), 0);
    reset_n = 1'b1;
    kick(8'd2, 1'b0);
    run_measure(-1, -1, 1'b0, von, baf, dn, fr);
    check("rs_first_rem", fr, 2);
    check("rs_valve", von, 8);
    check("rs_cool", baf, 8);
    check("rs_cnt", 32'(io.run_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
